chimp_seq_ctrl: RTL and testbench

- Parametrised control FSM for the chimp-test memory game.
- Sequences start, board load, ordered number selection, level-up, fail and win.
- Sits between the keyboard/space decoder and the board datapath (tile placer, click checker, VGA drawer).
- Level, selection index and best score are registered counters, so arbitrary depth needs no per-number states. Numbers are hidden after the first correct pick.

---
 rtl/chimp_seq_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_chimp_seq_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/chimp_seq_ctrl.sv
// Control FSM for the chimp-test memory game: start, load, ordered picks, level-up, fail, win.
// Optional macro CHIMP_STRIKES_EN adds a strike budget (STRIKES, oStrikesLeft) and a RETRY state.
module chimp_seq_ctrl #(
    parameter int MAX_LEVEL   = 31,
    parameter int START_LEVEL = 4,
    parameter int NUM_W       = 5
`ifdef CHIMP_STRIKES_EN
    ,
    parameter int STRIKES     = 3
`endif
) (
    input  logic             clk,
    input  logic             iReset,
    input  logic             iSpace,
    input  logic             iDoneLoad,
    input  logic             iChoseCorrectNum,
    input  logic             iChoseWrongNum,
    output logic [NUM_W-1:0] oNumToChoose,
    output logic [NUM_W-1:0] oLevel,
    output logic [NUM_W-1:0] oBestLevel,
    output logic             oLoadEnable,
    output logic             oShowEnable,
    output logic             oResetBoard,
    output logic             oWin,
`ifdef CHIMP_STRIKES_EN
    output logic [$clog2(STRIKES+1)-1:0] oStrikesLeft,
`endif
    output logic [2:0]       oState
);

    if (START_LEVEL < 1 || START_LEVEL > MAX_LEVEL || MAX_LEVEL >= (1 << NUM_W)) begin : g_bad_params
        $error("chimp_seq_ctrl: need 1 <= START_LEVEL <= MAX_LEVEL < 2**NUM_W");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_LOAD   = 3'd2,
        S_CHOOSE = 3'd3,
        S_PASS   = 3'd4,
        S_FAIL   = 3'd5,
        S_WIN    = 3'd6
`ifdef CHIMP_STRIKES_EN
        ,
        S_RETRY  = 3'd7
`endif
    } state_t;

    localparam logic [NUM_W-1:0] L_START = NUM_W'(START_LEVEL);
    localparam logic [NUM_W-1:0] L_MAX   = NUM_W'(MAX_LEVEL);
    localparam logic [NUM_W-1:0] L_ONE   = NUM_W'(1);

    state_t           r_state;
    state_t           w_next;
    logic [NUM_W-1:0] r_level;
    logic [NUM_W-1:0] r_num;
    logic [NUM_W-1:0] r_best;

`ifdef CHIMP_STRIKES_EN
    localparam int SW = $clog2(STRIKES + 1);
    localparam logic [SW-1:0] L_STRIKES = SW'(STRIKES);

    if (STRIKES < 1) begin : g_bad_strikes
        $error("chimp_seq_ctrl: STRIKES must be >= 1");
    end

    logic [SW-1:0] r_strikes;
    logic          w_last_strike;
    assign w_last_strike = (r_strikes <= SW'(1));
    assign oStrikesLeft  = r_strikes;
`endif

    // NOTE: state and counters are flops, so they use non-blocking assignments only.
    always_ff @(posedge clk or posedge iReset) begin
        if (iReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets a default first so no path through the case can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (iSpace)     w_next = S_ARM;
            S_ARM:   if (!iSpace)    w_next = S_LOAD;
            S_LOAD:  if (iDoneLoad)  w_next = S_CHOOSE;
            S_CHOOSE: begin
                if (iChoseWrongNum) begin
`ifdef CHIMP_STRIKES_EN
                    w_next = w_last_strike ? S_FAIL : S_RETRY;
`else
                    w_next = S_FAIL;
`endif
                end else if (iChoseCorrectNum && r_num >= r_level) begin
                    w_next = S_PASS;
                end
            end
            S_PASS:  w_next = (r_level == L_MAX) ? S_WIN : S_LOAD;
            S_FAIL:  w_next = S_IDLE;
            S_WIN:   if (iSpace)     w_next = S_ARM;
`ifdef CHIMP_STRIKES_EN
            S_RETRY: w_next = S_LOAD;
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // Level, selection index and best score live outside the state encoding.
    always_ff @(posedge clk or posedge iReset) begin
        if (iReset) begin
            r_level   <= L_START;
            r_num     <= '0;
            r_best    <= '0;
`ifdef CHIMP_STRIKES_EN
            r_strikes <= L_STRIKES;
`endif
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (iDoneLoad) r_num <= L_ONE;
                end
                S_CHOOSE: begin
                    if (iChoseWrongNum) begin
`ifdef CHIMP_STRIKES_EN
                        if (!w_last_strike) r_strikes <= r_strikes - SW'(1);
`endif
                    end else if (iChoseCorrectNum && r_num < r_level) begin
                        r_num <= r_num + L_ONE;
                    end
                end
                S_PASS: begin
                    r_num <= '0;
                    if (r_level > r_best) r_best  <= r_level;
                    if (r_level < L_MAX)  r_level <= r_level + L_ONE;
                end
                S_FAIL: begin
                    r_num   <= '0;
                    r_level <= L_START;
`ifdef CHIMP_STRIKES_EN
                    r_strikes <= L_STRIKES;
`endif
                end
                S_WIN: begin
                    if (iSpace) r_level <= L_START;
                end
`ifdef CHIMP_STRIKES_EN
                S_RETRY: r_num <= '0;
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        oLoadEnable  = 1'b0;
        oShowEnable  = 1'b0;
        oResetBoard  = 1'b0;
        oWin         = 1'b0;
        oNumToChoose = '0;
        case (r_state)
            S_IDLE, S_ARM, S_PASS, S_FAIL: oResetBoard = 1'b1;
            S_LOAD: begin
                oLoadEnable = 1'b1;
                oShowEnable = 1'b1;
            end
            S_CHOOSE: begin
                oNumToChoose = r_num;
                oShowEnable  = (r_num == L_ONE);
            end
            S_WIN: begin
                oWin        = 1'b1;
                oShowEnable = 1'b1;
            end
`ifdef CHIMP_STRIKES_EN
            S_RETRY: oResetBoard = 1'b1;
`endif
            default: ;
        endcase
    end

    assign oLevel     = r_level;
    assign oBestLevel = r_best;
    assign oState     = r_state;

endmodule

// File: tb/tb_chimp_seq_ctrl.sv
// Table-driven bench for chimp_seq_ctrl (MAX_LEVEL=5, START_LEVEL=4) with an expected-value queue.
module tb_chimp_seq_ctrl;

    localparam int NUM_W = 5;

    typedef struct packed {
        logic [2:0]       st;
        logic [NUM_W-1:0] num;
        logic [NUM_W-1:0] lvl;
        logic [NUM_W-1:0] best;
        logic [3:0]       flg;   // {load, show, reset_board, win}
    } exp_t;

    typedef struct {
        logic [3:0] in;          // {space, done, correct, wrong}
        exp_t       exp;
    } vec_t;

    localparam logic [3:0] F_RB   = 4'b0010;
    localparam logic [3:0] F_LOAD = 4'b1100;
    localparam logic [3:0] F_SHOW = 4'b0100;
    localparam logic [3:0] F_HID  = 4'b0000;
    localparam logic [3:0] F_WIN  = 4'b0101;

    logic             clk = 1'b0;
    logic             iReset, iSpace, iDoneLoad, iChoseCorrectNum, iChoseWrongNum;
    logic [NUM_W-1:0] oNumToChoose, oLevel, oBestLevel;
    logic             oLoadEnable, oShowEnable, oResetBoard, oWin;
    logic [2:0]       oState;
`ifdef CHIMP_STRIKES_EN
    logic [1:0]       oStrikesLeft;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[$];
    exp_t sb[$];

    chimp_seq_ctrl #(.MAX_LEVEL(5), .START_LEVEL(4), .NUM_W(NUM_W)) dut (
        .clk              (clk),
        .iReset           (iReset),
        .iSpace           (iSpace),
        .iDoneLoad        (iDoneLoad),
        .iChoseCorrectNum (iChoseCorrectNum),
        .iChoseWrongNum   (iChoseWrongNum),
        .oNumToChoose     (oNumToChoose),
        .oLevel           (oLevel),
        .oBestLevel       (oBestLevel),
        .oLoadEnable      (oLoadEnable),
        .oShowEnable      (oShowEnable),
        .oResetBoard      (oResetBoard),
        .oWin             (oWin),
`ifdef CHIMP_STRIKES_EN
        .oStrikesLeft     (oStrikesLeft),
`endif
        .oState           (oState)
    );

    always #5 clk = ~clk;

    function automatic exp_t sample();
        exp_t a;
        a.st   = oState;
        a.num  = oNumToChoose;
        a.lvl  = oLevel;
        a.best = oBestLevel;
        a.flg  = {oLoadEnable, oShowEnable, oResetBoard, oWin};
        return a;
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got st=%0d num=%0d lvl=%0d best=%0d flg=%b, want st=%0d num=%0d lvl=%0d best=%0d flg=%b",
                     name, got.st, got.num, got.lvl, got.best, got.flg,
                     want.st, want.num, want.lvl, want.best, want.flg);
        end
    endtask

    task automatic add(input logic [3:0] in, input int st, input int num, input int lvl,
                       input int best, input logic [3:0] flg);
        vec_t v;
        v.in       = in;
        v.exp.st   = 3'(st);
        v.exp.num  = NUM_W'(num);
        v.exp.lvl  = NUM_W'(lvl);
        v.exp.best = NUM_W'(best);
        v.exp.flg  = flg;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [3:0] in);
        {iSpace, iDoneLoad, iChoseCorrectNum, iChoseWrongNum} = in;
    endtask

    initial begin
        exp_t want;
        iReset = 1'b1;
        drive(4'b0000);

        // Stimulus table: inputs applied before an edge, outputs expected after it.
        repeat (10) add(4'b0000, 0, 0, 4, 0, F_RB);
        add(4'b0011, 0, 0, 4, 0, F_RB);             // picks ignored in IDLE
        add(4'b0100, 0, 0, 4, 0, F_RB);             // done ignored in IDLE
        repeat (5)  add(4'b1000, 1, 0, 4, 0, F_RB); // ARM while space held
        add(4'b0000, 2, 0, 4, 0, F_LOAD);
        add(4'b1000, 2, 0, 4, 0, F_LOAD);           // space ignored in LOAD
        add(4'b0010, 2, 0, 4, 0, F_LOAD);           // pick ignored in LOAD
        add(4'b0100, 3, 1, 4, 0, F_SHOW);
        add(4'b0000, 3, 1, 4, 0, F_SHOW);
        add(4'b0010, 3, 2, 4, 0, F_HID);
        add(4'b1000, 3, 2, 4, 0, F_HID);            // space ignored in CHOOSE
        add(4'b0010, 3, 3, 4, 0, F_HID);
        add(4'b0010, 3, 4, 4, 0, F_HID);
        add(4'b0010, 4, 0, 4, 0, F_RB);             // PASS
        add(4'b0000, 2, 0, 5, 4, F_LOAD);
        add(4'b0100, 3, 1, 5, 4, F_SHOW);
        add(4'b0010, 3, 2, 5, 4, F_HID);
        add(4'b0010, 3, 3, 5, 4, F_HID);
        add(4'b0011, 5, 0, 5, 4, F_RB);             // wrong beats correct -> FAIL
        add(4'b0000, 0, 0, 4, 4, F_RB);
        add(4'b1000, 1, 0, 4, 4, F_RB);
        add(4'b0000, 2, 0, 4, 4, F_LOAD);
        add(4'b0100, 3, 1, 4, 4, F_SHOW);
        for (int n = 2; n <= 4; n++) add(4'b0010, 3, n, 4, 4, F_HID);
        add(4'b0010, 4, 0, 4, 4, F_RB);
        add(4'b0000, 2, 0, 5, 4, F_LOAD);
        add(4'b0100, 3, 1, 5, 4, F_SHOW);
        for (int n = 2; n <= 5; n++) add(4'b0010, 3, n, 5, 4, F_HID);
        add(4'b0010, 4, 0, 5, 4, F_RB);             // PASS at MAX_LEVEL
        add(4'b0000, 6, 0, 5, 5, F_WIN);
        add(4'b0110, 6, 0, 5, 5, F_WIN);            // done/pick ignored in WIN
        add(4'b0001, 6, 0, 5, 5, F_WIN);
        add(4'b1000, 1, 0, 4, 5, F_RB);
        add(4'b1000, 1, 0, 4, 5, F_RB);
        add(4'b0000, 2, 0, 4, 5, F_LOAD);
        add(4'b0100, 3, 1, 4, 5, F_SHOW);
        add(4'b0010, 3, 2, 4, 5, F_HID);

        repeat (2) @(posedge clk);
        #1;
        want = '{st: 3'd0, num: '0, lvl: NUM_W'(4), best: '0, flg: F_RB};
        check("reset_values", sample(), want);
        @(negedge clk);
        iReset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].in);
            sb.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL scoreboard_underflow at vec%0d", i);
            end else begin
                check($sformatf("vec%0d", i), sample(), sb.pop_front());
            end
        end

        // Async reset mid-CHOOSE: takes effect with clk low, no edge needed.
        @(negedge clk);
        drive(4'b0000);
        #2 iReset = 1'b1;
        #1;
        want = '{st: 3'd0, num: '0, lvl: NUM_W'(4), best: '0, flg: F_RB};
        check("async_reset_mid_choose", sample(), want);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", sample(), want);
        @(negedge clk);
        iReset = 1'b0;
        iSpace = 1'b1;
        @(posedge clk);
        #1;
        want = '{st: 3'd1, num: '0, lvl: NUM_W'(4), best: '0, flg: F_RB};
        check("restart_after_reset", sample(), want);

        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
